expr_eval_seq: RTL and testbench
================================

Name: expr_eval_seq

Overview:
Clocked, parametrised ASCII arithmetic-expression evaluator. It consumes one character per valid cycle, e.g. "12+34*5-6=". It supports multi-digit decimal operands, binary '+', '-' and '*' with standard precedence ('*' binds tighter), and '=' as terminator. It reports the WIDTH-bit two's-complement result, or an error flag for malformed input. It sits behind a character source (keyboard/UART-style byte stream) in the P1 calculator path.

Parameters:
WIDTH, 16, bit width of all accumulators and of the result; arithmetic is modulo 2^WIDTH.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (sampled on rising edge of clk; 0 = reset)
in  input  8  ASCII character: '0'-'9', '+', '-', '*', '='
in_valid  input  1  in is consumed on a rising edge where in_valid=1; ignored otherwise
result  output  WIDTH  value of last completed expression; 0 if that expression errored
done  output  1  one-cycle pulse, cycle after '=' is consumed
error  output  1  valid while done=1 and held until next done; 1 = last expression malformed
busy  output  1  1 while an expression is partially received (state NUM/OP/ERR)

Behaviour:
- Reset (reset=0 at edge): state=START; result=0, done=0, error=0, busy=0; internal sum=0, term=1, num=0, sign=+. Reset overrides in_valid. A mid-expression reset discards all partial state.
- Internal registers (all WIDTH bits, truncating): num (current operand), term (product of '*'-chained operands), sum (accumulated additive terms), sign (1 bit, sign applied to the current term).
- States:
  - START: expecting the first digit of an expression.
  - NUM: inside an operand.
  - OP: operator just received, expecting a digit.
  - ERR: malformed input seen, waiting for '='.
- Transitions and actions, taken only when in_valid=1:
  - Digit d in START/OP/NUM: num <= num*10 + d, truncated to WIDTH; go to NUM.
  - '*' in NUM: term <= term*num (truncated); num <= 0; go to OP.
  - '+' or '-' in NUM: sum <= sum ± (term*num) per sign; term <= 1; num <= 0; sign <= new operator; go to OP.
  - '=' in NUM: next cycle result <= sum ± term*num and done=1, error=0. Clear sum/term/num/sign to reset values; go to START.
  - Operator in START/OP (leading operator, two operators in a row): go to ERR.
  - '=' in START/OP (empty expression, trailing operator): error completion.
  - Any character outside the accepted set, in any non-ERR state: go to ERR.
  - Any non-'=' character in ERR: stay in ERR.
  - '=' in ERR: error completion.
- Error completion: next cycle result <= 0, done=1, error=1; clear accumulators; go to START.
- Latency: exactly 1 cycle from the edge consuming '=' to done=1. done is high for exactly 1 cycle. result and error hold their values until the next completion.
- busy=1 in NUM/OP/ERR and 0 in START; it drops in the same cycle done rises.
- A valid character arriving in the cycle done is high is processed normally as the start of the next expression.
- No unary minus. A leading zero is a normal digit ("007" = 7).
- Negative results appear in two's complement.

Test Plan:
1. WIDTH=16, "1*2*3+4=" on consecutive cycles -> done one cycle after '='; result=10, error=0; busy=0 after.
2. "12+34*5-6=" -> result=176 (precedence honoured, multi-digit operands).
3. WIDTH=16, "3-10=" -> result=16'hFFF9, error=0. WIDTH=8, "200*2=" -> result=144 (wrap). WIDTH=8, "300=" -> result=44.
4. "1+*2=" -> done with error=1, result=0. Then "7=" -> result=7, error=0. Also "=" alone -> error=1. "4+=" -> error=1. "5a=" -> error=1.
5. "9*8=" with in_valid deasserted for 3 cycles between characters, and 'X' presented while in_valid=0 -> result=72, error=0, no spurious done.
6. "5*" then reset=0 for one cycle then "2=" -> result=2, error=0; outputs read 0 and busy=0 during reset. Also back-to-back: "1=" immediately followed by "2=" -> two done pulses, results 1 then 2.

Source files
------------

// File: rtl/expr_eval_seq.sv
// Streaming ASCII expression evaluator: one character per valid cycle, '+', '-'
// and '*' with '*' binding tighter, '=' terminates and reports result/error.
module expr_eval_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             error,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_START,
    ST_NUM,
    ST_OP,
    ST_ERR
  } state_t;

  typedef enum logic [2:0] {
    CH_DIGIT,
    CH_MUL,
    CH_ADD,
    CH_SUB,
    CH_EQ,
    CH_BAD
  } char_t;

  localparam logic [WIDTH-1:0] TEN = WIDTH'(10);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  char_t            char_class;
  logic [WIDTH-1:0] digit_val;
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] acc;
  logic             finish_ok;
  logic             finish_err;

  always_comb begin
    char_class = CH_BAD;
    if (in >= 8'h30 && in <= 8'h39) begin
      char_class = CH_DIGIT;
    end else begin
      case (in)
        8'h2A:   char_class = CH_MUL;
        8'h2B:   char_class = CH_ADD;
        8'h2D:   char_class = CH_SUB;
        8'h3D:   char_class = CH_EQ;
        default: char_class = CH_BAD;
      endcase
    end
  end

  // For an ASCII digit the low nibble is already its value.
  assign digit_val = {{(WIDTH-4){1'b0}}, in[3:0]};
  assign prod      = term_q * num_q;
  assign acc       = sign_q ? (sum_q - prod) : (sum_q + prod);

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    term_d     = term_q;
    sum_d      = sum_q;
    sign_d     = sign_q;
    result_d   = result_q;
    done_d     = 1'b0;
    error_d    = error_q;
    finish_ok  = 1'b0;
    finish_err = 1'b0;

    if (in_valid) begin
      if (state_q == ST_ERR) begin
        if (char_class == CH_EQ) begin
          finish_err = 1'b1;
        end
      end else begin
        case (char_class)
          CH_DIGIT: begin
            num_d   = num_q * TEN + digit_val;
            state_d = ST_NUM;
          end
          CH_MUL: begin
            if (state_q == ST_NUM) begin
              term_d  = prod;
              num_d   = '0;
              state_d = ST_OP;
            end else begin
              state_d = ST_ERR;
            end
          end
          CH_ADD, CH_SUB: begin
            if (state_q == ST_NUM) begin
              sum_d   = acc;
              term_d  = ONE;
              num_d   = '0;
              sign_d  = (char_class == CH_SUB);
              state_d = ST_OP;
            end else begin
              state_d = ST_ERR;
            end
          end
          CH_EQ: begin
            if (state_q == ST_NUM) begin
              finish_ok = 1'b1;
            end else begin
              finish_err = 1'b1;
            end
          end
          default: state_d = ST_ERR;
        endcase
      end
    end

    // Both completions return the accumulators to their idle values.
    if (finish_ok || finish_err) begin
      result_d = finish_ok ? acc : '0;
      error_d  = finish_err;
      done_d   = 1'b1;
      num_d    = '0;
      term_d   = ONE;
      sum_d    = '0;
      sign_d   = 1'b0;
      state_d  = ST_START;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_START;
      num_q    <= '0;
      term_q   <= ONE;
      sum_q    <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      term_q   <= term_d;
      sum_q    <= sum_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign error  = error_q;
  assign busy   = (state_q != ST_START);

endmodule

// File: tb/tb_expr_eval_seq.sv
// Bench for expr_eval_seq: WIDTH=16 and WIDTH=8 instances fed the same stream,
// directed table, reset/back-to-back sequences, then random expressions vs a model.
module tb_expr_eval_seq;

  logic        clk;
  logic        reset;
  logic [7:0]  in;
  logic        in_valid;
  logic [15:0] result16;
  logic        done16, error16, busy16;
  logic [7:0]  result8;
  logic        done8, error8, busy8;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  expr_eval_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .result(result16), .done(done16), .error(error16), .busy(busy16)
  );

  expr_eval_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .result(result8), .done(done8), .error(error8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       s;
    int          gap;
    int          idle;
    logic [15:0] r16;
    logic [7:0]  r8;
    logic        err;
  } vec_t;

  typedef struct {
    logic [15:0] r16;
    logic [7:0]  r8;
    logic        err;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: validate the whole string first, then split into operands and
  // operators and fold '*' runs into terms before summing them.
  function automatic longint model(input string s, input int w, output bit err);
    longint     mask;
    longint     nums[$];
    logic [7:0] ops[$];
    longint     cur, sum, prod;
    bit         have, neg;
    logic [7:0] c;
    mask = (longint'(1) << w) - 1;
    err  = 0;
    cur  = 0;
    have = 0;
    if (s.len() == 0 || s[s.len()-1] != "=") err = 1;
    for (int i = 0; i < s.len() - 1; i++) begin
      c = s[i];
      if (c >= "0" && c <= "9") begin
        cur  = (cur * 10 + longint'(c - "0")) & mask;
        have = 1;
      end else if (c == "+" || c == "-" || c == "*") begin
        if (!have) err = 1;
        nums.push_back(cur);
        ops.push_back(c);
        cur  = 0;
        have = 0;
      end else begin
        err = 1;
      end
    end
    if (!have) err = 1;
    nums.push_back(cur);
    if (err) return 0;
    sum  = 0;
    prod = nums[0];
    neg  = 0;
    for (int i = 0; i < ops.size(); i++) begin
      if (ops[i] == "*") begin
        prod = (prod * nums[i+1]) & mask;
      end else begin
        sum  = neg ? sum - prod : sum + prod;
        neg  = (ops[i] == "-");
        prod = nums[i+1];
      end
    end
    sum = neg ? sum - prod : sum + prod;
    return sum & mask;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in       = 8'h58;
    end
  endtask

  // Each character is preceded by 'gap' idle cycles carrying junk on in.
  task automatic send_expr(input string s, input int gap, input logic [15:0] r16,
                           input logic [7:0] r8, input logic err, input bit expect_done);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      repeat (gap) begin
        @(negedge clk);
        in_valid = 1'b0;
        in       = (i % 2 == 0) ? 8'h58 : 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      in       = s[i];
      in_valid = 1'b1;
    end
    if (expect_done) begin
      e.r16 = r16;
      e.r8  = r8;
      e.err = err;
      e.cyc = cyc + 1;
      e.tag = s;
      sbq.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (done16 || done8) begin
      chk("done_pair", longint'(done8), longint'(done16));
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_done: done seen at cycle %0d, expected none", cyc);
      end else begin
        e = sbq.pop_front();
        $display("done  expr=%-24s r16=0x%04h e16=%0d r8=0x%02h e8=%0d cyc=%0d",
                 e.tag, result16, error16, result8, error8, cyc);
        chk({"latency ", e.tag}, longint'(cyc), longint'(e.cyc));
        chk({"result16 ", e.tag}, longint'(result16), longint'(e.r16));
        chk({"error16 ", e.tag}, longint'(error16), longint'(e.err));
        chk({"result8 ", e.tag}, longint'(result8), longint'(e.r8));
        chk({"error8 ", e.tag}, longint'(error8), longint'(e.err));
        chk({"busy16_at_done ", e.tag}, longint'(busy16), 0);
        chk({"busy8_at_done ", e.tag}, longint'(busy8), 0);
      end
    end
  end

  vec_t       vecs[13];
  logic [7:0] bad_chars[6];

  initial begin
    string       s;
    bit          e16, e8;
    longint      m16, m8;
    int          nops, ndig;
    logic [7:0]  c;
    logic [7:0]  op_chars[3];

    vecs[0]  = '{"1*2*3+4=",   0, 2, 16'd10,     8'd10,   1'b0};
    vecs[1]  = '{"12+34*5-6=", 0, 2, 16'd176,    8'd176,  1'b0};
    vecs[2]  = '{"3-10=",      0, 1, 16'hFFF9,   8'hF9,   1'b0};
    vecs[3]  = '{"200*2=",     0, 1, 16'd400,    8'd144,  1'b0};
    vecs[4]  = '{"300=",       0, 1, 16'd300,    8'd44,   1'b0};
    vecs[5]  = '{"1+*2=",      0, 0, 16'd0,      8'd0,    1'b1};
    vecs[6]  = '{"7=",         0, 1, 16'd7,      8'd7,    1'b0};
    vecs[7]  = '{"=",          0, 1, 16'd0,      8'd0,    1'b1};
    vecs[8]  = '{"4+=",        0, 1, 16'd0,      8'd0,    1'b1};
    vecs[9]  = '{"5a=",        1, 1, 16'd0,      8'd0,    1'b1};
    vecs[10] = '{"9*8=",       3, 4, 16'd72,     8'd72,   1'b0};
    vecs[11] = '{"007=",       0, 1, 16'd7,      8'd7,    1'b0};
    vecs[12] = '{"65535+1=",   0, 2, 16'd0,      8'd0,    1'b0};

    bad_chars[0] = "a"; bad_chars[1] = "X"; bad_chars[2] = " ";
    bad_chars[3] = "+"; bad_chars[4] = "*"; bad_chars[5] = "/";
    op_chars[0]  = "+"; op_chars[1]  = "-"; op_chars[2]  = "*";

    reset    = 1'b0;
    in       = 8'h3D;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_result16", longint'(result16), 0);
    chk("reset_result8", longint'(result8), 0);
    chk("reset_done", longint'(done16 | done8), 0);
    chk("reset_error", longint'(error16 | error8), 0);
    chk("reset_busy", longint'(busy16 | busy8), 0);
    in_valid = 1'b0;
    reset    = 1'b1;
    idle(1);

    for (int i = 0; i < 13; i++) begin
      $display("vec   %0d expr=%s gap=%0d", i, vecs[i].s, vecs[i].gap);
      send_expr(vecs[i].s, vecs[i].gap, vecs[i].r16, vecs[i].r8, vecs[i].err, 1'b1);
      idle(vecs[i].idle);
    end

    // Mid-expression reset discards "5*"; outputs clear while reset is low.
    send_expr("5*", 0, 16'd0, 8'd0, 1'b0, 1'b0);
    idle(1);
    chk("busy_before_reset", longint'(busy16), 1);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_result16", longint'(result16), 0);
    chk("midreset_busy", longint'(busy16 | busy8), 0);
    chk("midreset_error", longint'(error16 | error8), 0);
    reset = 1'b1;
    send_expr("2=", 0, 16'd2, 8'd2, 1'b0, 1'b1);
    idle(1);

    // Back-to-back: second expression starts while done of the first is high.
    send_expr("1=", 0, 16'd1, 8'd1, 1'b0, 1'b1);
    send_expr("2=", 0, 16'd2, 8'd2, 1'b0, 1'b1);
    idle(1);
    send_expr("11*11-3=", 0, 16'd118, 8'd118, 1'b0, 1'b1);
    idle(2);

    for (int t = 0; t < 80; t++) begin
      s = "";
      nops = $urandom_range(0, 4);
      for (int k = 0; k <= nops; k++) begin
        ndig = $urandom_range(1, 5);
        for (int d = 0; d < ndig; d++) begin
          c = 8'($urandom_range(48, 57));
          if ($urandom_range(0, 40) == 0) c = bad_chars[$urandom_range(0, 5)];
          s = $sformatf("%s%c", s, c);
        end
        if (k < nops) s = $sformatf("%s%c", s, op_chars[$urandom_range(0, 2)]);
      end
      if ($urandom_range(0, 12) == 0) s = $sformatf("%s%c", s, op_chars[$urandom_range(0, 2)]);
      if ($urandom_range(0, 20) == 0) s = "";
      s = {s, "="};
      m16 = model(s, 16, e16);
      m8  = model(s, 8, e8);
      send_expr(s, $urandom_range(0, 2), 16'(m16), 8'(m8), logic'(e16), 1'b1);
      idle($urandom_range(0, 2));
    end

    idle(4);
    chk("scoreboard_drained", longint'(sbq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
